// File: rtl/vector_dot_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_dot_pkg                                                        |
// | Shared encodings for the vector_dot_dma slave and its loader.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package vector_dot_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_LATCH   = 4'd2,
    S_WRITE   = 4'd3,
    S_TRIGGER = 4'd4,
    S_WAIT    = 4'd5,
    S_READ    = 4'd6,
    S_CAPTURE = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam int unsigned TRIG_ADDR = 0;
  localparam logic [31:0] TRIG_DATA = 32'h0000_0000;
  localparam int unsigned RES_ADDR  = 0;

  localparam logic BUF_A = 1'b0;
  localparam logic BUF_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vector_dot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vector_dot_loader                                                     |
// | Fetches vectors A and B from memory into the dot slave, triggers it   |
// | and captures the result.                                              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module vector_dot_loader
  import vector_dot_pkg::*;
#(
  parameter int MEM_AW    = 16,
  parameter int DOT_AW    = 3,
  parameter int MAX_LEN   = 6,
  parameter int CALC_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MEM_AW-1:0] a_base,
  input  logic [MEM_AW-1:0] b_base,
  input  logic [7:0]        length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       result,
  output logic [MEM_AW-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  output logic [DOT_AW-1:0] dot_address,
  output logic [31:0]       dot_writedata,
  output logic              dot_write,
  output logic              dot_read,
  output logic              dot_b_data,
  input  logic [31:0]       dot_readdata
);

  localparam int WAIT_W = (CALC_WAIT > 1) ? $clog2(CALC_WAIT) : 1;

  state_t              r_state;
  logic [7:0]          r_i;
  logic [7:0]          r_len;
  logic                r_ph;
  logic [31:0]         r_wd;
  logic [WAIT_W-1:0]   r_wait;
  logic [MEM_AW-1:0]   r_a_base;
  logic [MEM_AW-1:0]   r_b_base;

  logic [7:0]          w_next_i;
  logic [MEM_AW-1:0]   w_next_addr;

  assign w_next_i      = r_i + 8'd1;
  assign w_next_addr   = (r_ph ? r_b_base : r_a_base) + MEM_AW'(w_next_i);
  // The data register doubles as the write-data bus, so the trigger just loads TRIG_DATA.
  assign dot_writedata = r_wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_len       <= '0;
      r_ph        <= 1'b0;
      r_wd        <= '0;
      r_wait      <= '0;
      r_a_base    <= '0;
      r_b_base    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      result      <= '0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      dot_address <= '0;
      dot_write   <= 1'b0;
      dot_read    <= 1'b0;
      dot_b_data  <= 1'b0;
    end else begin
      done      <= 1'b0;
      dot_write <= 1'b0;
      dot_read  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (length == 8'd0) begin
              result  <= '0;
              err     <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else if (length > 8'(MAX_LEN)) begin
              err     <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_a_base    <= a_base;
              r_b_base    <= b_base;
              r_len       <= length;
              r_i         <= '0;
              r_ph        <= BUF_A;
              err         <= 1'b0;
              busy        <= 1'b1;
              mem_read    <= 1'b1;
              mem_address <= a_base;
              r_state     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (!mem_waitrequest) begin
            mem_read <= 1'b0;
            r_state  <= S_LATCH;
          end
        end
        S_LATCH: begin
          r_wd        <= mem_readdata;
          dot_write   <= 1'b1;
          dot_address <= r_i[DOT_AW-1:0];
          dot_b_data  <= r_ph;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          if (r_i != r_len - 8'd1) begin
            r_i         <= w_next_i;
            mem_read    <= 1'b1;
            mem_address <= w_next_addr;
            r_state     <= S_FETCH;
          end else if (r_ph == BUF_A) begin
            r_ph        <= BUF_B;
            r_i         <= '0;
            mem_read    <= 1'b1;
            mem_address <= r_b_base;
            r_state     <= S_FETCH;
          end else begin
            r_wd        <= TRIG_DATA;
            dot_write   <= 1'b1;
            dot_address <= DOT_AW'(TRIG_ADDR);
            dot_b_data  <= BUF_B;
            r_state     <= S_TRIGGER;
          end
        end
        S_TRIGGER: begin
          if (CALC_WAIT == 0) begin
            dot_read    <= 1'b1;
            dot_address <= DOT_AW'(RES_ADDR);
            r_state     <= S_READ;
          end else begin
            r_wait  <= WAIT_W'(CALC_WAIT - 1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait == '0) begin
            dot_read    <= 1'b1;
            dot_address <= DOT_AW'(RES_ADDR);
            r_state     <= S_READ;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_READ: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          result  <= dot_readdata;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_dot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vector_dot_loader                                                  |
// | Directed bench with memory/slave models and a write/read scoreboard.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_vector_dot_loader;
  import vector_dot_pkg::*;

  localparam int MEM_AW    = 16;
  localparam int DOT_AW    = 3;
  localparam int MAX_LEN   = 6;
  localparam int CALC_WAIT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a_base, b_base;
  logic [7:0]  length;
  logic        busy, done, err;
  logic [31:0] result;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [2:0]  dot_address;
  logic [31:0] dot_writedata;
  logic        dot_write, dot_read, dot_b_data;
  logic [31:0] dot_readdata;

  always #5 clk = ~clk;

  vector_dot_loader #(
    .MEM_AW(MEM_AW), .DOT_AW(DOT_AW), .MAX_LEN(MAX_LEN), .CALC_WAIT(CALC_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .a_base(a_base), .b_base(b_base),
    .length(length), .busy(busy), .done(done), .err(err), .result(result),
    .mem_address(mem_address), .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .dot_address(dot_address), .dot_writedata(dot_writedata),
    .dot_write(dot_write), .dot_read(dot_read), .dot_b_data(dot_b_data),
    .dot_readdata(dot_readdata)
  );

  // Memory model: data one cycle after an accepted read, stall_n waitrequest cycles per read.
  logic [31:0] mem [0:65535];
  int          stall_n = 0;
  int          wcnt;

  always_comb mem_waitrequest = mem_read && (wcnt < stall_n);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt         <= 0;
      mem_readdata <= '0;
    end else if (mem_read && !mem_waitrequest) begin
      mem_readdata <= mem[mem_address];
      wcnt         <= 0;
    end else if (mem_read) begin
      wcnt <= wcnt + 1;
    end
  end

  // Slave model: first 2N writes fill the buffers, the next one is the trigger.
  logic [31:0] sa [0:7];
  logic [31:0] sb [0:7];
  logic [31:0] slv_res;
  int          slv_len = 0;
  int          wr_idx;

  function automatic real fp2r(logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return m;
  endfunction

  function automatic logic [31:0] r2fp(real v);
    int          e;
    logic [22:0] f;
    e = 0;
    if (v <= 0.0) return 32'h0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    f = 23'($rtoi((v - 1.0) * 8388608.0 + 0.5));
    return {1'b0, 8'(e + 127), f};
  endfunction

  function automatic logic [31:0] dot_fp(int n);
    real s;
    s = 0.0;
    for (int k = 0; k < n; k++) s = s + fp2r(sa[k]) * fp2r(sb[k]);
    return r2fp(s);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx       <= 0;
      dot_readdata <= '0;
    end else begin
      if (dot_write) begin
        if (wr_idx < 2 * slv_len) begin
          if (dot_b_data) sb[dot_address] <= dot_writedata;
          else            sa[dot_address] <= dot_writedata;
          wr_idx <= wr_idx + 1;
        end else begin
          slv_res <= dot_fp(slv_len);
          wr_idx  <= 0;
        end
      end
      if (dot_read) dot_readdata <= slv_res;
    end
  end

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] data;
    logic        bsel;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];

  int checks = 0;
  int errors = 0;
  int cyc, done_cnt, done_cyc, strobe_cnt;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle and check the bus activity of the new cycle against the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_read || dot_write || dot_read) strobe_cnt++;
    if (mem_read) begin
      chk("rd_wr_exclusive", 64'(dot_write), 64'd0);
      chk("rd_pending", 64'(exp_rd.size() != 0), 64'd1);
      if (exp_rd.size() != 0) begin
        chk("mem_address", 64'(mem_address), 64'(exp_rd[0]));
        if (!mem_waitrequest) void'(exp_rd.pop_front());
      end
    end
    if (dot_write) begin
      chk("wr_pending", 64'(exp_wr.size() != 0), 64'd1);
      if (exp_wr.size() != 0) begin
        chk("dot_write", 64'({dot_address, dot_writedata, dot_b_data}), 64'(exp_wr[0]));
        void'(exp_wr.pop_front());
      end
    end
    if (dot_read) chk("res_addr", 64'(dot_address), 64'(RES_ADDR));
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic push_run(logic [15:0] a, logic [15:0] b, int n);
    logic [15:0] addr;
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < n; k++) begin
        addr = (ph == 1 ? b : a) + 16'(k);
        exp_rd.push_back(addr);
        exp_wr.push_back({3'(k), mem[addr], 1'(ph)});
      end
    end
    exp_wr.push_back({3'(TRIG_ADDR), TRIG_DATA, BUF_B});
  endtask

  task automatic run(logic [15:0] a, logic [15:0] b, logic [7:0] n, int stalls, bit toggle);
    a_base  = a;
    b_base  = b;
    length  = n;
    stall_n = stalls;
    slv_len = int'(n);
    if (n >= 8'd1 && n <= 8'(MAX_LEN)) push_run(a, b, int'(n));
    start      = 1'b1;
    cyc        = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    strobe_cnt = 0;
    tick();
    start = 1'b0;
    if (n >= 8'd1 && n <= 8'(MAX_LEN)) chk("busy_cycle1", 64'(busy), 64'd1);
    for (int t = 0; t < 300 && done_cnt == 0; t++) begin
      if (toggle) start = cyc[0];
      tick();
    end
    start = 1'b0;
    chk("done_seen", 64'(done_cnt), 64'd1);
  endtask

  task automatic settle(string tag);
    tick();
    tick();
    chk({tag, "_queues_empty"}, 64'(exp_rd.size() + exp_wr.size()), 64'd0);
    chk({tag, "_single_done"}, 64'(done_cnt), 64'd1);
  endtask

  function automatic int exp_done(int n, int stalls);
    return 2 * n * (3 + stalls) + CALC_WAIT + 4;
  endfunction

  initial begin
    logic [31:0] vals [0:5];
    vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000;
    vals[3] = 32'h40800000; vals[4] = 32'h40A00000; vals[5] = 32'h40C00000;
    for (int k = 0; k < 65536; k++) mem[k] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      mem[16'h0010 + k] = vals[k];
      mem[16'h0020 + k] = vals[k];
    end
    mem[16'hFFFE] = vals[0];
    mem[16'hFFFF] = vals[1];
    mem[16'h0000] = vals[2];
    mem[16'h0001] = vals[3];

    reset  = 1'b1;
    start  = 1'b0;
    a_base = '0;
    b_base = '0;
    length = '0;
    cyc    = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({busy, done, err, mem_read, dot_write, dot_read, dot_b_data}), 64'd0);
    chk("reset_data", 64'({result, dot_writedata}), 64'd0);
    chk("reset_addr", 64'({mem_address, dot_address}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Nominal N=6
    run(16'h0010, 16'h0020, 8'd6, 0, 1'b0);
    chk("nom_done_cycle", 64'(done_cyc), 64'(exp_done(6, 0)));
    chk("nom_result", 64'(result), 64'h42B60000);
    chk("nom_err", 64'(err), 64'd0);
    chk("nom_busy_at_done", 64'(busy), 64'd0);
    settle("nom");

    // Length above MAX_LEN
    run(16'h0010, 16'h0020, 8'd7, 0, 1'b0);
    chk("len7_done_cycle", 64'(done_cyc), 64'd1);
    chk("len7_err", 64'(err), 64'd1);
    chk("len7_result_held", 64'(result), 64'h42B60000);
    chk("len7_no_strobes", 64'(strobe_cnt), 64'd0);
    settle("len7");

    // Length zero
    run(16'h0010, 16'h0020, 8'd0, 0, 1'b0);
    chk("len0_done_cycle", 64'(done_cyc), 64'd1);
    chk("len0_err", 64'(err), 64'd0);
    chk("len0_result", 64'(result), 64'd0);
    chk("len0_no_strobes", 64'(strobe_cnt), 64'd0);
    settle("len0");

    // Two waitrequest cycles on every read
    run(16'h0010, 16'h0020, 8'd3, 2, 1'b0);
    chk("ws_done_cycle", 64'(done_cyc), 64'(exp_done(3, 2)));
    chk("ws_result", 64'(result), 64'h41600000);
    settle("ws");

    // Address wrap of the A vector
    run(16'hFFFE, 16'h0020, 8'd4, 0, 1'b0);
    chk("wrap_done_cycle", 64'(done_cyc), 64'(exp_done(4, 0)));
    chk("wrap_result", 64'(result), 64'h41F00000);
    settle("wrap");

    // Asynchronous reset during the B phase
    a_base  = 16'h0010;
    b_base  = 16'h0020;
    length  = 8'd6;
    stall_n = 0;
    slv_len = 6;
    push_run(16'h0010, 16'h0020, 6);
    start    = 1'b1;
    cyc      = 0;
    done_cnt = 0;
    tick();
    start = 1'b0;
    repeat (24) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_ctrl", 64'({busy, done, err, mem_read, dot_write, dot_read, dot_b_data}), 64'd0);
    chk("mid_reset_data", 64'({result, dot_writedata}), 64'd0);
    chk("mid_reset_addr", 64'({mem_address, dot_address}), 64'd0);
    exp_rd.delete();
    exp_wr.delete();
    #2 reset = 1'b0;
    run(16'h0010, 16'h0020, 8'd2, 0, 1'b0);
    chk("post_reset_done_cycle", 64'(done_cyc), 64'(exp_done(2, 0)));
    chk("post_reset_result", 64'(result), 64'h40A00000);
    settle("post_reset");

    // start toggled while busy and held in the DONE cycle
    run(16'h0010, 16'h0020, 8'd3, 0, 1'b1);
    chk("toggle_done_cycle", 64'(done_cyc), 64'(exp_done(3, 0)));
    chk("toggle_result", 64'(result), 64'h41600000);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done_ignored", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("toggle_single_done", 64'(done_cnt), 64'd1);
    chk("toggle_queues_empty", 64'(exp_rd.size() + exp_wr.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
